// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC sequencing, load-use stall, branch redirect and halt.
// Optional `FETCH_CTRL_STATS_EN adds saturating stall/flush event counters.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic [1:0]  ctrl_state
`ifdef FETCH_CTRL_STATS_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      HALT  = 2'b10
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc_next;
   logic        hazard;

   assign hazard     = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   assign pc_plus4   = pc + 32'd4;
   assign ctrl_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      case (state)
         RUN: begin
            if (branch_taken)  pc_next = branch_target;
            else if (hazard)   state_next = STALL;
            else if (halt_req) state_next = HALT;
            else               pc_next = pc_plus4;
         end
         // The stalled instruction is released unconditionally; hazard and halt are not re-evaluated.
         STALL: begin
            state_next = RUN;
            pc_next    = branch_taken ? branch_target : pc_plus4;
         end
         HALT: begin
            if (resume) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!rst_n) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (branch_taken) begin
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
               end else if (hazard) begin
                  idex_bubble = 1'b1;
               end else if (halt_req) begin
                  ifid_flush = 1'b1;
               end else begin
                  ifid_en = 1'b1;
               end
            end
            STALL: begin
               ifid_en    = 1'b1;
               ifid_flush = branch_taken;
            end
            HALT: idex_bubble = 1'b1;
            default: begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end
         endcase
      end
   end

`ifdef FETCH_CTRL_STATS_EN
   logic stall_evt, flush_evt;

   assign stall_evt = (state == RUN) && !branch_taken && hazard;
   assign flush_evt = ((state == RUN) || (state == STALL)) && branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
         if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a cycle-level reference model queues expected outputs,
// a negedge monitor compares them against the DUT. Counters checked when FETCH_CTRL_STATS_EN is set.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        ex_memread, branch_taken, halt_req, resume;
   logic [31:0] branch_target;
   logic [31:0] pc, pc_plus4;
   logic        ifid_en, ifid_flush, idex_bubble;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .halt_req(halt_req), .resume(resume),
      .pc(pc), .pc_plus4(pc_plus4), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .ctrl_state(ctrl_state)
`ifdef FETCH_CTRL_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

`ifndef FETCH_CTRL_STATS_EN
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] pc, pc4;
      logic        en, fl, bub, bub_dc;
      logic [1:0]  st;
      logic [15:0] sc, fc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   int   cyc = 0;

   // Reference model: mode 0 running, 1 one-cycle load-use stall, 2 halted.
   int          m_mode = 0;
   logic [31:0] m_pc = RST_PC;
   int          m_sc = 0, m_fc = 0;

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, want);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("pc", e.cyc, pc, e.pc);
         chk("pc_plus4", e.cyc, pc_plus4, e.pc4);
         chk("ifid_en", e.cyc, 32'(ifid_en), 32'(e.en));
         chk("ifid_flush", e.cyc, 32'(ifid_flush), 32'(e.fl));
         if (!e.bub_dc) chk("idex_bubble", e.cyc, 32'(idex_bubble), 32'(e.bub));
         chk("ctrl_state", e.cyc, 32'(ctrl_state), 32'(e.st));
`ifdef FETCH_CTRL_STATS_EN
         chk("stall_cnt", e.cyc, 32'(stall_cnt), 32'(e.sc));
         chk("flush_cnt", e.cyc, 32'(flush_cnt), 32'(e.fc));
`endif
      end
   end

   // Predict outputs for the current inputs, advance the model, then move to the next cycle.
   task automatic cycle();
      exp_t e;
      logic hz;
      hz = ex_memread && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
      if (!rst_n) begin
         m_pc = RST_PC; m_mode = 0; m_sc = 0; m_fc = 0;
      end
      e.cyc = cyc; e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.st = 2'(m_mode);
      e.sc = 16'(m_sc); e.fc = 16'(m_fc); e.bub_dc = 1'b0;
      if (!rst_n) begin
         e.en = 0; e.fl = 1; e.bub = 1;
      end else if (m_mode == 0) begin
         if (branch_taken) begin
            e.en = 1; e.fl = 1; e.bub = 0; m_pc = branch_target;
            if (m_fc < 65535) m_fc++;
         end else if (hz) begin
            e.en = 0; e.fl = 0; e.bub = 1; m_mode = 1;
            if (m_sc < 65535) m_sc++;
         end else if (halt_req) begin
            e.en = 0; e.fl = 1; e.bub = 0; e.bub_dc = 1; m_mode = 2;
         end else begin
            e.en = 1; e.fl = 0; e.bub = 0; m_pc = m_pc + 32'd4;
         end
      end else if (m_mode == 1) begin
         e.en = 1; e.fl = branch_taken; e.bub = 0; m_mode = 0;
         if (branch_taken) begin
            m_pc = branch_target;
            if (m_fc < 65535) m_fc++;
         end else m_pc = m_pc + 32'd4;
      end else begin
         e.en = 0; e.fl = 0; e.bub = 1;
         if (resume) m_mode = 0;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
      branch_taken = 0; branch_target = 0; halt_req = 0; resume = 0;
   endtask

   task automatic branch_to(input logic [31:0] t);
      idle(); branch_taken = 1; branch_target = t; cycle(); idle();
   endtask

   initial begin
      rst_n = 0;
      idle();
      @(posedge clk);
      #1;
      cycle(); cycle();
      rst_n = 1;
      repeat (4) cycle();

      // load-use hazard at 0x20, hazard held into the stall cycle
      branch_to(32'h20);
      ex_memread = 1; ex_rt = 5; id_rs = 5; id_rt = 9;
      cycle(); cycle(); idle(); cycle();
      ex_memread = 1; ex_rt = 7; id_rs = 1; id_rt = 7; cycle(); idle();
      // x0 load never stalls
      ex_memread = 1; ex_rt = 0; id_rs = 0; id_rt = 0; cycle(); cycle(); idle();
      // branch beats hazard
      ex_memread = 1; ex_rt = 3; id_rs = 3; branch_taken = 1; branch_target = 32'h400;
      cycle(); idle(); cycle();
      // halt at 0x40, branch ignored in HALT, resume after 5 cycles
      branch_to(32'h40);
      halt_req = 1; cycle(); halt_req = 0;
      branch_taken = 1; branch_target = 32'h800; cycle(); cycle(); idle();
      cycle(); cycle();
      resume = 1; cycle(); resume = 0; cycle(); cycle();
      // resume outside HALT, wraparound, unmasked target
      resume = 1; cycle(); resume = 0;
      branch_to(32'hFFFF_FFFC); cycle(); cycle();
      branch_to(32'h0000_0403); cycle();
      // reset asserted while halted and while stalled
      halt_req = 1; cycle(); idle(); cycle();
      rst_n = 0; cycle(); rst_n = 1; cycle(); cycle();
      ex_memread = 1; ex_rt = 2; id_rt = 2; cycle(); idle();
      rst_n = 0; cycle(); rst_n = 1; cycle(); cycle();

      for (int i = 0; i < 2000; i++) begin
         rst_n         = ($urandom_range(199) != 0);
         ex_memread    = ($urandom_range(2) == 0);
         ex_rt         = 5'($urandom_range(3));
         id_rs         = 5'($urandom_range(3));
         id_rt         = 5'($urandom_range(3));
         branch_taken  = ($urandom_range(7) == 0);
         branch_target = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(7)) : $urandom;
         halt_req      = ($urandom_range(29) == 0);
         resume        = ($urandom_range(3) == 0);
         cycle();
      end
      rst_n = 1;
      idle();

      @(negedge clk);
      #1;
      chk("scoreboard_drain", cyc, 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
